// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - control-bundle bit map and bubble constant for the MIPS pipeline
package mips_pipe_pkg;

  localparam int CTRL_REGDST   = 0;
  localparam int CTRL_BRANCHNE = 1;
  localparam int CTRL_BRANCHEQ = 2;
  localparam int CTRL_ALUOP_LO = 3;
  localparam int CTRL_ALUOP_HI = 5;
  localparam int CTRL_ALUSRC   = 6;
  localparam int CTRL_REGWRITE = 7;
  localparam int CTRL_MEMWRITE = 8;
  localparam int CTRL_MEMREAD  = 9;
  localparam int CTRL_MEMTOREG = 10;
  localparam int CTRL_SHAMTSEL = 11;
  localparam int CTRL_REGORPC  = 12;
  localparam int CTRL_ALUMEMPC = 13;
  localparam int CTRL_JUMP     = 14;
  localparam int CTRL_W        = 15;

  // All-zero bundle: no register write, memory access, branch or jump
  localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard check between EX and ID
module load_use_detect #(
  parameter int RBits = 5
) (
  input  logic             ex_mem_read,
  input  logic             ex_valid,
  input  logic [RBits-1:0] ex_write_reg,
  input  logic [RBits-1:0] id_rs,
  input  logic [RBits-1:0] id_rt,
  input  logic             id_rt_used,
  output logic             hazard
);

  logic dest_nonzero;
  logic rs_match;
  logic rt_match;

  // $0 is hardwired to zero, so a load targeting it can never feed a consumer
  assign dest_nonzero = (ex_write_reg != '0);
  assign rs_match     = (ex_write_reg == id_rs);
  assign rt_match     = id_rt_used && (ex_write_reg == id_rt);
  assign hazard       = ex_mem_read && ex_valid && dest_nonzero && (rs_match || rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall and flush; ID_EX_PERF_EN adds counters
module id_ex_stage
  import mips_pipe_pkg::*;
#(
  parameter int NBits = 32,
  parameter int RBits = 5,
  parameter int CBits = CTRL_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CBits-1:0] id_ctrl,
  input  logic [NBits-1:0] id_read_data1,
  input  logic [NBits-1:0] id_read_data2,
  input  logic [NBits-1:0] id_imm_ext,
  input  logic [NBits-1:0] id_shamt_ext,
  input  logic [NBits-1:0] id_pc_plus4,
  input  logic [RBits-1:0] id_rs,
  input  logic [RBits-1:0] id_rt,
  input  logic             id_rt_used,
  input  logic [RBits-1:0] id_write_reg,
  input  logic             flush,
  output logic [CBits-1:0] ex_ctrl,
  output logic [NBits-1:0] ex_read_data1,
  output logic [NBits-1:0] ex_read_data2,
  output logic [NBits-1:0] ex_imm_ext,
  output logic [NBits-1:0] ex_shamt_ext,
  output logic [NBits-1:0] ex_pc_plus4,
  output logic [RBits-1:0] ex_rs,
  output logic [RBits-1:0] ex_rt,
  output logic [RBits-1:0] ex_write_reg,
  output logic             ex_valid,
  output logic             stall
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]      stall_count,
  output logic [31:0]      flush_count
`endif
);

  logic hazard;

  load_use_detect #(.RBits(RBits)) u_load_use_detect (
    .ex_mem_read  (ex_ctrl[CTRL_MEMREAD]),
    .ex_valid     (ex_valid),
    .ex_write_reg (ex_write_reg),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rt_used   (id_rt_used),
    .hazard       (hazard)
  );

  // A flushed decode instruction is discarded, so holding it upstream would be pointless
  assign stall = hazard && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_ctrl       <= BUBBLE_CTRL;
      ex_read_data1 <= '0;
      ex_read_data2 <= '0;
      ex_imm_ext    <= '0;
      ex_shamt_ext  <= '0;
      ex_pc_plus4   <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_write_reg  <= '0;
      ex_valid      <= 1'b0;
    end else if (flush || hazard) begin
      ex_ctrl       <= BUBBLE_CTRL;
      ex_read_data1 <= '0;
      ex_read_data2 <= '0;
      ex_imm_ext    <= '0;
      ex_shamt_ext  <= '0;
      ex_pc_plus4   <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_write_reg  <= '0;
      ex_valid      <= 1'b0;
    end else begin
      ex_ctrl       <= id_ctrl;
      ex_read_data1 <= id_read_data1;
      ex_read_data2 <= id_read_data2;
      ex_imm_ext    <= id_imm_ext;
      ex_shamt_ext  <= id_shamt_ext;
      ex_pc_plus4   <= id_pc_plus4;
      ex_rs         <= id_rs;
      ex_rt         <= id_rt;
      ex_write_reg  <= id_write_reg;
      ex_valid      <= 1'b1;
    end
  end

`ifdef ID_EX_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && (stall_count != '1)) stall_count <= stall_count + 32'd1;
      if (flush && (flush_count != '1)) flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

  localparam logic [14:0] LW_CTRL   = 15'h06C0;
  localparam logic [14:0] ADD_CTRL  = 15'h0091;
  localparam logic [14:0] ADDI_CTRL = 15'h00C0;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] id_ctrl;
  logic [31:0] id_read_data1, id_read_data2, id_imm_ext, id_shamt_ext, id_pc_plus4;
  logic [4:0]  id_rs, id_rt, id_write_reg;
  logic        id_rt_used, flush;
  logic [14:0] ex_ctrl;
  logic [31:0] ex_read_data1, ex_read_data2, ex_imm_ext, ex_shamt_ext, ex_pc_plus4;
  logic [4:0]  ex_rs, ex_rt, ex_write_reg;
  logic        ex_valid, stall;
`ifdef ID_EX_PERF_EN
  logic [31:0] stall_count, flush_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_ctrl(id_ctrl),
    .id_read_data1(id_read_data1), .id_read_data2(id_read_data2),
    .id_imm_ext(id_imm_ext), .id_shamt_ext(id_shamt_ext), .id_pc_plus4(id_pc_plus4),
    .id_rs(id_rs), .id_rt(id_rt), .id_rt_used(id_rt_used), .id_write_reg(id_write_reg),
    .flush(flush), .ex_ctrl(ex_ctrl),
    .ex_read_data1(ex_read_data1), .ex_read_data2(ex_read_data2),
    .ex_imm_ext(ex_imm_ext), .ex_shamt_ext(ex_shamt_ext), .ex_pc_plus4(ex_pc_plus4),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_write_reg(ex_write_reg),
    .ex_valid(ex_valid), .stall(stall)
`ifdef ID_EX_PERF_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [14:0] c, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] wr, input logic rtu);
    id_ctrl       = c;
    id_rs         = rs;
    id_rt         = rt;
    id_write_reg  = wr;
    id_rt_used    = rtu;
    id_read_data1 = 32'h1100_0000 | {27'd0, rs};
    id_read_data2 = 32'h2200_0000 | {27'd0, rt};
    id_imm_ext    = 32'hFFFF_FF00 | {27'd0, wr};
    id_shamt_ext  = 32'h0000_001F;
    id_pc_plus4   = 32'h0040_0000 | {17'd0, c};
  endtask

  task automatic test_reset();
    reset = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(15'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom));
      tick();
      if ({ex_ctrl, ex_read_data1, ex_read_data2, ex_imm_ext, ex_shamt_ext, ex_pc_plus4,
           ex_rs, ex_rt, ex_write_reg} !== '0) begin
        bad++; $display("FAIL reset_outputs ctrl=%h rd1=%h exp=0", ex_ctrl, ex_read_data1);
      end
      total++;
      if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", ex_valid); end
      total++;
      if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
      total++;
    end
    drive(15'h1234, 5'd3, 5'd4, 5'd0, 1'b1);
    id_read_data1 = 32'hDEADBEEF;
    reset = 1'b1;
    tick();
    if (ex_ctrl !== 15'h1234) begin bad++; $display("FAIL release_ctrl got=%h exp=1234", ex_ctrl); end
    total++;
    if (ex_read_data1 !== 32'hDEADBEEF) begin
      bad++; $display("FAIL release_rd1 got=%h exp=deadbeef", ex_read_data1);
    end
    total++;
    if (ex_valid !== 1'b1) begin bad++; $display("FAIL release_valid got=%b exp=1", ex_valid); end
    total++;
  endtask

  task automatic test_load_use_rs();
    drive(15'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    drive(LW_CTRL, 5'd1, 5'd8, 5'd8, 1'b0);
    tick();
    if (ex_ctrl !== LW_CTRL || ex_write_reg !== 5'd8) begin
      bad++; $display("FAIL lw_capture ctrl=%h wr=%0d exp ctrl=%h wr=8", ex_ctrl, ex_write_reg, LW_CTRL);
    end
    total++;
    drive(ADD_CTRL, 5'd8, 5'd3, 5'd10, 1'b1);
    #1;
    if (stall !== 1'b1) begin bad++; $display("FAIL rs_stall got=%b exp=1", stall); end
    total++;
    tick();
    if (ex_valid !== 1'b0 || ex_ctrl !== 15'd0 || ex_rs !== 5'd0 || ex_read_data1 !== 32'd0) begin
      bad++; $display("FAIL rs_bubble valid=%b ctrl=%h rs=%0d exp 0/0/0", ex_valid, ex_ctrl, ex_rs);
    end
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL rs_stall_clear got=%b exp=0", stall); end
    total++;
    tick();
    if (ex_valid !== 1'b1 || ex_ctrl !== ADD_CTRL || ex_rs !== 5'd8 || ex_write_reg !== 5'd10) begin
      bad++; $display("FAIL rs_resume valid=%b ctrl=%h rs=%0d wr=%0d exp 1/%h/8/10",
                      ex_valid, ex_ctrl, ex_rs, ex_write_reg, ADD_CTRL);
    end
    total++;
  endtask

  task automatic test_rt_gate();
    drive(LW_CTRL, 5'd1, 5'd9, 5'd9, 1'b0);
    tick();
    drive(ADDI_CTRL, 5'd2, 5'd9, 5'd9, 1'b0);
    #1;
    if (stall !== 1'b0) begin bad++; $display("FAIL rt_unused_stall got=%b exp=0", stall); end
    total++;
    tick();
    if (ex_valid !== 1'b1 || ex_ctrl !== ADDI_CTRL) begin
      bad++; $display("FAIL rt_unused_capture valid=%b ctrl=%h exp 1/%h", ex_valid, ex_ctrl, ADDI_CTRL);
    end
    total++;
    drive(LW_CTRL, 5'd1, 5'd9, 5'd9, 1'b0);
    tick();
    drive(ADD_CTRL, 5'd2, 5'd9, 5'd11, 1'b1);
    #1;
    if (stall !== 1'b1) begin bad++; $display("FAIL rt_used_stall got=%b exp=1", stall); end
    total++;
    tick();
    if (ex_valid !== 1'b0 || ex_ctrl !== 15'd0) begin
      bad++; $display("FAIL rt_used_bubble valid=%b ctrl=%h exp 0/0", ex_valid, ex_ctrl);
    end
    total++;
    tick();
  endtask

  task automatic test_zero_dest();
    drive(LW_CTRL, 5'd1, 5'd0, 5'd0, 1'b0);
    tick();
    drive(ADD_CTRL, 5'd0, 5'd0, 5'd12, 1'b1);
    #1;
    if (stall !== 1'b0) begin bad++; $display("FAIL zero_stall got=%b exp=0", stall); end
    total++;
    tick();
    if (ex_valid !== 1'b1 || ex_ctrl !== ADD_CTRL || ex_write_reg !== 5'd12) begin
      bad++; $display("FAIL zero_capture valid=%b ctrl=%h wr=%0d exp 1/%h/12",
                      ex_valid, ex_ctrl, ex_write_reg, ADD_CTRL);
    end
    total++;
  endtask

  task automatic test_flush();
    drive(LW_CTRL, 5'd1, 5'd5, 5'd5, 1'b0);
    tick();
    drive(ADD_CTRL, 5'd5, 5'd6, 5'd13, 1'b1);
    flush = 1'b1;
    #1;
    if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b exp=0", stall); end
    total++;
    tick();
    flush = 1'b0;
    if (ex_valid !== 1'b0 || ex_ctrl !== 15'd0 || ex_pc_plus4 !== 32'd0 || ex_write_reg !== 5'd0) begin
      bad++; $display("FAIL flush_bubble valid=%b ctrl=%h pc=%h exp 0/0/0", ex_valid, ex_ctrl, ex_pc_plus4);
    end
    total++;
    drive(ADD_CTRL, 5'd5, 5'd6, 5'd13, 1'b1);
    #1;
    if (stall !== 1'b0) begin bad++; $display("FAIL flush_after_stall got=%b exp=0", stall); end
    total++;
    tick();
    if (ex_valid !== 1'b1 || ex_write_reg !== 5'd13) begin
      bad++; $display("FAIL flush_resume valid=%b wr=%0d exp 1/13", ex_valid, ex_write_reg);
    end
    total++;
  endtask

  task automatic test_back_to_back();
    logic [14:0] ctrls [3];
    ctrls[0] = 15'h7FFF & ~15'h0200;
    ctrls[1] = 15'h0001;
    ctrls[2] = 15'h4000;
    for (int i = 0; i < 3; i++) begin
      drive(ctrls[i], 5'(i + 20), 5'(i + 24), 5'(i + 28), 1'b1);
      tick();
      if (ex_ctrl !== ctrls[i] || ex_rs !== 5'(i + 20) || ex_rt !== 5'(i + 24) ||
          ex_read_data2 !== (32'h2200_0000 | (i + 24)) ||
          ex_imm_ext !== (32'hFFFF_FF00 | (i + 28)) || ex_shamt_ext !== 32'h1F ||
          ex_pc_plus4 !== (32'h0040_0000 | {17'd0, ctrls[i]})) begin
        bad++; $display("FAIL b2b_%0d ctrl=%h rs=%0d rt=%0d rd2=%h imm=%h pc=%h exp ctrl=%h",
                        i, ex_ctrl, ex_rs, ex_rt, ex_read_data2, ex_imm_ext, ex_pc_plus4, ctrls[i]);
      end
      total++;
    end
    // asynchronous reset mid-stream, then normal capture on first edge
    #2 reset = 1'b0;
    #1;
    if (ex_valid !== 1'b0 || ex_ctrl !== 15'd0) begin
      bad++; $display("FAIL async_reset valid=%b ctrl=%h exp 0/0", ex_valid, ex_ctrl);
    end
    total++;
    reset = 1'b1;
    drive(ADD_CTRL, 5'd7, 5'd7, 5'd7, 1'b1);
    tick();
    if (ex_valid !== 1'b1 || ex_ctrl !== ADD_CTRL || stall !== 1'b0) begin
      bad++; $display("FAIL post_reset valid=%b ctrl=%h stall=%b exp 1/%h/0", ex_valid, ex_ctrl, stall, ADD_CTRL);
    end
    total++;
  endtask

`ifdef ID_EX_PERF_EN
  task automatic test_perf();
    reset = 1'b0;
    #2 reset = 1'b1;
    if (stall_count !== 32'd0 || flush_count !== 32'd0) begin
      bad++; $display("FAIL perf_reset stall_count=%0d flush_count=%0d exp 0/0", stall_count, flush_count);
    end
    total++;
    for (int i = 0; i < 3; i++) begin
      drive(LW_CTRL, 5'd1, 5'd7, 5'd7, 1'b0);
      tick();
      drive(ADD_CTRL, 5'd7, 5'd2, 5'd3, 1'b1);
      tick();
      tick();
    end
    flush = 1'b1;
    tick();
    tick();
    flush = 1'b0;
    if (stall_count !== 32'd3 || flush_count !== 32'd2) begin
      bad++; $display("FAIL perf_counts stall_count=%0d flush_count=%0d exp 3/2", stall_count, flush_count);
    end
    total++;
    force dut.stall_count = 32'hFFFF_FFFF;
    #1;
    release dut.stall_count;
    drive(LW_CTRL, 5'd1, 5'd7, 5'd7, 1'b0);
    tick();
    drive(ADD_CTRL, 5'd7, 5'd2, 5'd3, 1'b1);
    tick();
    if (stall_count !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL perf_saturate stall_count=%h exp ffffffff", stall_count);
    end
    total++;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_load_use_rs();
    test_rt_gate();
    test_zero_dest();
    test_flush();
    test_back_to_back();
`ifdef ID_EX_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between instruction decode and execute in the MIPS datapath.
- Captures the decode stage's control bundle, register-file read data, extended immediate/shamt, PC+4 and register indices each cycle.
- Contains load-use hazard detection: it stalls PC and IF/ID and inserts a bubble into execute.
- Accepts a flush from branch/jump resolution to squash the instruction in decode.

Parameters:
- NBits, 32, datapath width for read data, immediate, shamt and PC+4.
- RBits, 5, register index width.
- CBits, 15, width of the packed control bundle (bit map in package).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- id_ctrl  input  CBits  packed decode control: RegDst, BranchNE, BranchEQ, ALUOp[2:0], ALUSrc, RegWrite, MemWrite, MemRead, MemtoReg, ShamtSelector, RegisterOrPC, ALUMemOrPC, JumpControl.
- id_read_data1 / id_read_data2  input  NBits  register-file outputs.
- id_imm_ext / id_shamt_ext  input  NBits  sign-extended immediate / zero-extended shamt.
- id_pc_plus4  input  NBits  PC+4 of the decode instruction.
- id_rs / id_rt  input  RBits  instruction fields [25:21], [20:16].
- id_rt_used  input  1  decode instruction reads rt as a source (R-type, beq/bne, sw).
- id_write_reg  input  RBits  final destination index (after RegDst/ra mux).
- flush  input  1  branch taken or jump resolved; squash the instruction in decode.
- ex_ctrl  output  CBits  registered control bundle.
- ex_read_data1, ex_read_data2, ex_imm_ext, ex_shamt_ext, ex_pc_plus4  output  NBits  registered data.
- ex_rs, ex_rt, ex_write_reg  output  RBits  registered indices.
- ex_valid  output  1  execute holds a real instruction, not a bubble.
- stall  output  1  hold PC and IF/ID this cycle.

Behaviour:
- Reset (reset=0, async): all ex_* outputs = 0, ex_valid = 0; stall = 0 as a consequence.
- Latency: one cycle; inputs present at edge N appear on outputs after edge N.
- Hazard (combinational from registered state and ID inputs): hazard = ex_ctrl.MemRead & ex_valid & (ex_write_reg != 0) & ((ex_write_reg == id_rs) | (id_rt_used & ex_write_reg == id_rt)).
- stall = hazard & ~flush; no registered delay.
- Per-edge priority: reset > flush > hazard > capture.
  - flush=1: load bubble (ex_ctrl=0, all data/indices=0, ex_valid=0). Flush overrides hazard.
  - hazard=1: load bubble. ID inputs are held upstream by stall and re-sampled next cycle.
  - otherwise: capture all id_* inputs, ex_valid=1.
- Bubble guarantee: RegWrite, MemWrite, MemRead, Branch* and JumpControl are all 0, so execute has no architectural side effect.
- A second consecutive hazard is impossible, because the bubble clears ex_valid. Each stall therefore lasts exactly one cycle per load-use pair.
- Register $0 destination never triggers a stall.
- Reset deasserted mid-stream: the first edge after release captures normally; no stale stall.

Optional Feature:
- Macro ID_EX_PERF_EN.
- Defined: adds outputs stall_count and flush_count (32 bits each).
  - Each increments on edges where stall or flush, respectively, was 1.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package mips_pipe_pkg: bit-index constants for the control bundle (CTRL_REGDST=0 … CTRL_JUMP=14), CTRL_W=15, and the BUBBLE_CTRL constant (all zeros).
- Sub-module load_use_detect: combinational hazard equation, reusable by a later forwarding unit.
- Register bank and priority logic stay in id_ex_stage.

Test Plan:
- Reset: hold reset=0 with random id_* -> all outputs 0, ex_valid=0, stall=0; release -> next edge captures id_ctrl=0x1234 and id_read_data1=0xDEADBEEF unchanged.
- Load-use on rs:
  - Cycle 1: lw $8 (MemRead=1, write_reg=8).
  - Cycle 2: add with rs=8 -> stall=1 during cycle 2.
  - Next edge: ex_valid=0, ex_ctrl=0.
  - Following edge: add captured with stall=0.
- Load-use on rt gated: lw $9, then addi rt=9 with id_rt_used=0 -> stall=0. Same with id_rt_used=1 -> stall=1.
- $0 exemption: lw $0, then add rs=0 -> stall=0 and normal capture.
- Flush priority: hazard condition active and flush=1 in the same cycle -> stall=0; next edge bubble loaded, ex_valid=0.
- With ID_EX_PERF_EN: 3 stalls and 2 flushes -> stall_count=3, flush_count=2; preload the counter to 0xFFFFFFFF and stall -> stays 0xFFFFFFFF.
